// File: rtl/uart_alu_packet_parser_if.sv
// Byte stream in, tagged payload words out, plus status, between the UART receiver and the ALU core.
interface uart_alu_packet_parser_if;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic [7:0]  opcode_o;
  logic [15:0] len_o;
  logic [31:0] data_o;
  logic [2:0]  bytes_o;
  logic        first_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;
  logic        err_o;
  logic        busy_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, opcode_o, len_o, data_o, bytes_o, first_o, last_o, valid_o, err_o, busy_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, opcode_o, len_o, data_o, bytes_o, first_o, last_o, valid_o, err_o, busy_o
  );
endinterface

// File: rtl/uart_alu_packet_parser.sv
// Decodes the 4-byte packet header and packs the payload into little-endian 32-bit words;
// malformed packets raise err_o and have their payload swallowed to keep the stream aligned.
module uart_alu_packet_parser #(
  parameter logic [15:0] MAX_LEN_P = 16'd1024,
  parameter logic [7:0]  OP_ECHO_P = 8'hEC,
  parameter logic [7:0]  OP_ADD_P  = 8'hA1,
  parameter logic [7:0]  OP_MUL_P  = 8'hA2,
  parameter logic [7:0]  OP_DIV_P  = 8'hA3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  uart_alu_packet_parser_if.slave   bus_if
);

  localparam logic [2:0] ST_OPCODE  = 3'd0;
  localparam logic [2:0] ST_RSVD    = 3'd1;
  localparam logic [2:0] ST_LEN_LO  = 3'd2;
  localparam logic [2:0] ST_LEN_HI  = 3'd3;
  localparam logic [2:0] ST_EMPTY   = 3'd4;
  localparam logic [2:0] ST_PAYLOAD = 3'd5;
  localparam logic [2:0] ST_DISCARD = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [15:0] len_q, len_d;
  logic [15:0] rem_q, rem_d;
  logic [31:0] acc_q, acc_d;
  logic [1:0]  idx_q, idx_d;
  logic        first_pend_q, first_pend_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  bytes_q, bytes_d;
  logic        first_q, first_d;
  logic        last_q, last_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        ready_s;
  logic        accept_s;
  logic        out_hs_s;
  logic        op_ok_s;
  logic [15:0] hdr_len_s;
  logic [31:0] acc_next_s;

  assign accept_s   = bus_if.valid_i & ready_s;
  assign out_hs_s   = valid_q & bus_if.ready_i;
  assign hdr_len_s  = {bus_if.data_i, len_q[7:0]};
  assign op_ok_s    = (opcode_q == OP_ECHO_P) || (opcode_q == OP_ADD_P) ||
                      (opcode_q == OP_MUL_P)  || (opcode_q == OP_DIV_P);
  assign acc_next_s = acc_q | ({24'd0, bus_if.data_i} << {idx_q, 3'd0});

  // Byte acceptance: payload stalls once all bytes are in or a word is stuck downstream.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_OPCODE, ST_RSVD, ST_LEN_LO, ST_LEN_HI, ST_DISCARD: ready_s = 1'b1;
      ST_PAYLOAD: ready_s = (rem_q != 16'd0) && !(valid_q && !bus_if.ready_i);
      default:    ready_s = 1'b0;
    endcase
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d      = state_q;
    opcode_d     = opcode_q;
    len_d        = len_q;
    rem_d        = rem_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    first_pend_d = first_pend_q;
    data_d       = data_q;
    bytes_d      = bytes_q;
    first_d      = first_q;
    last_d       = last_q;
    valid_d      = valid_q;
    err_d        = 1'b0;
    case (state_q)
      ST_OPCODE: begin
        if (accept_s) begin
          opcode_d = bus_if.data_i;
          state_d  = ST_RSVD;
        end else begin
          state_d  = ST_OPCODE;
        end
      end
      ST_RSVD: begin
        if (accept_s) state_d = ST_LEN_LO;
        else          state_d = ST_RSVD;
      end
      ST_LEN_LO: begin
        if (accept_s) begin
          len_d   = {len_q[15:8], bus_if.data_i};
          state_d = ST_LEN_HI;
        end else begin
          state_d = ST_LEN_LO;
        end
      end
      ST_LEN_HI: begin
        if (accept_s) begin
          len_d = hdr_len_s;
          // Short length is tested first so remaining is never computed from L<4.
          if (hdr_len_s < 16'd4) begin
            err_d   = 1'b1;
            state_d = ST_OPCODE;
          end else if (!op_ok_s || (hdr_len_s > MAX_LEN_P)) begin
            err_d   = 1'b1;
            rem_d   = hdr_len_s - 16'd4;
            state_d = (hdr_len_s == 16'd4) ? ST_OPCODE : ST_DISCARD;
          end else if (hdr_len_s == 16'd4) begin
            data_d  = 32'd0;
            bytes_d = 3'd0;
            first_d = 1'b1;
            last_d  = 1'b1;
            valid_d = 1'b1;
            state_d = ST_EMPTY;
          end else begin
            rem_d        = hdr_len_s - 16'd4;
            acc_d        = 32'd0;
            idx_d        = 2'd0;
            first_pend_d = 1'b1;
            state_d      = ST_PAYLOAD;
          end
        end else begin
          state_d = ST_LEN_HI;
        end
      end
      ST_EMPTY: begin
        if (out_hs_s) begin
          valid_d = 1'b0;
          state_d = ST_OPCODE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_PAYLOAD: begin
        if (out_hs_s) begin
          valid_d = 1'b0;
          state_d = last_q ? ST_OPCODE : ST_PAYLOAD;
        end else begin
          state_d = ST_PAYLOAD;
        end
        if (accept_s) begin
          rem_d = rem_q - 16'd1;
          if ((idx_q == 2'd3) || (rem_q == 16'd1)) begin
            data_d       = acc_next_s;
            bytes_d      = {1'b0, idx_q} + 3'd1;
            first_d      = first_pend_q;
            last_d       = (rem_q == 16'd1);
            valid_d      = 1'b1;
            acc_d        = 32'd0;
            idx_d        = 2'd0;
            first_pend_d = 1'b0;
          end else begin
            acc_d = acc_next_s;
            idx_d = idx_q + 2'd1;
          end
        end else begin
          rem_d = rem_q;
        end
      end
      ST_DISCARD: begin
        if (accept_s) begin
          rem_d   = rem_q - 16'd1;
          state_d = (rem_q == 16'd1) ? ST_OPCODE : ST_DISCARD;
        end else begin
          state_d = ST_DISCARD;
        end
      end
      default: state_d = ST_OPCODE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= ST_OPCODE;
      opcode_q     <= 8'd0;
      len_q        <= 16'd0;
      rem_q        <= 16'd0;
      acc_q        <= 32'd0;
      idx_q        <= 2'd0;
      first_pend_q <= 1'b0;
      data_q       <= 32'd0;
      bytes_q      <= 3'd0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      len_q        <= len_d;
      rem_q        <= rem_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      first_pend_q <= first_pend_d;
      data_q       <= data_d;
      bytes_q      <= bytes_d;
      first_q      <= first_d;
      last_q       <= last_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign bus_if.ready_o  = ready_s;
  assign bus_if.opcode_o = opcode_q;
  assign bus_if.len_o    = len_q;
  assign bus_if.data_o   = data_q;
  assign bus_if.bytes_o  = bytes_q;
  assign bus_if.first_o  = first_q;
  assign bus_if.last_o   = last_q;
  assign bus_if.valid_o  = valid_q;
  assign bus_if.err_o    = err_q;
  assign bus_if.busy_o   = (state_q != ST_OPCODE);

endmodule

// File: tb/tb_uart_alu_packet_parser.sv
// Directed and random packets checked against a packet-level reference model of the parser.
module tb_uart_alu_packet_parser;

  logic clk;
  logic rst;

  uart_alu_packet_parser_if bus ();

  uart_alu_packet_parser dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  nbytes;
    logic        first;
    logic        last;
    logic [7:0]  op;
    logic [15:0] len;
  } word_t;

  word_t       exp_q[$];
  word_t       got_q[$];
  logic [7:0]  pkt[$];
  logic [7:0]  part[$];
  int          total = 0;
  int          bad = 0;
  int          err_seen = 0;
  int          exp_err = 0;
  logic        rand_ready = 1'b0;
  logic        ready_force = 1'b1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: what a whole packet should produce, by chunking its payload.
  function automatic void model(input logic [7:0] p[$]);
    int    len;
    int    n;
    int    nb;
    bit    op_ok;
    word_t w;
    len   = {p[3], p[2]};
    op_ok = (p[0] == 8'hEC) || (p[0] == 8'hA1) || (p[0] == 8'hA2) || (p[0] == 8'hA3);
    if (len < 4 || !op_ok || len > 1024) begin
      exp_err++;
    end else if (len == 4) begin
      w = '0;
      w.first = 1'b1; w.last = 1'b1; w.op = p[0]; w.len = len[15:0];
      exp_q.push_back(w);
    end else begin
      n = len - 4;
      for (int k = 0; k * 4 < n; k++) begin
        w = '0;
        nb = (n - 4 * k > 4) ? 4 : n - 4 * k;
        for (int b = 0; b < nb; b++) w.data[8*b +: 8] = p[4 + 4 * k + b];
        w.nbytes = nb[2:0];
        w.first  = (k == 0);
        w.last   = ((k + 1) * 4 >= n);
        w.op     = p[0];
        w.len    = len[15:0];
        exp_q.push_back(w);
      end
    end
  endfunction

  function automatic void build(input logic [7:0] op, input int len);
    pkt.delete();
    pkt.push_back(op);
    pkt.push_back(8'h00);
    pkt.push_back(len[7:0]);
    pkt.push_back(len[15:8]);
    for (int i = 4; i < len; i++) pkt.push_back(8'($urandom_range(0, 255)));
  endfunction

  task automatic send(input logic [7:0] p[$], input bit gaps);
    int n;
    bit done;
    for (int i = 0; i < p.size(); i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        bus.valid_i = 1'b0;
        @(posedge clk); #1;
      end
      bus.data_i  = p[i];
      bus.valid_i = 1'b1;
      n = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        done = bus.ready_o;
        @(posedge clk); #1;
        n++;
        if (!done && n > 200) begin
          total++;
          bad++;
          $error("FAIL send_timeout observed=stalled expected=byte %0d accepted", i);
          bus.valid_i = 1'b0;
          return;
        end
      end
    end
    bus.valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int    n;
    word_t e;
    word_t g;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      chk({tag, "_word"}, g, e);
    end
    exp_q.delete();
    got_q.delete();
    chk({tag, "_err"}, err_seen, exp_err);
  endtask

  // Output monitor: record handshaken words, count error pulses, check hold under stall.
  initial begin
    logic        stall;
    logic [31:0] held;
    word_t       w;
    stall = 1'b0;
    held  = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.err_o) err_seen++;
        if (stall && bus.valid_o) chk("hold_data", bus.data_o, held);
        if (bus.valid_o && bus.ready_i) begin
          w.data = bus.data_o; w.nbytes = bus.bytes_o; w.first = bus.first_o;
          w.last = bus.last_o; w.op = bus.opcode_o; w.len = bus.len_o;
          got_q.push_back(w);
        end
        stall = bus.valid_o && !bus.ready_i;
        held  = bus.data_o;
      end else begin
        stall = 1'b0;
      end
    end
  end

  // Downstream ready: forced level or random backpressure.
  initial begin
    bus.ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  initial begin
    int len;
    int sel;
    rst         = 1'b0;
    bus.data_i  = 8'd0;
    bus.valid_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", bus.valid_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    chk("rst_data", bus.data_o, 32'd0);
    chk("rst_opcode", bus.opcode_o, 8'd0);
    chk("rst_len", bus.len_o, 16'd0);
    chk("rst_bytes", bus.bytes_o, 3'd0);
    chk("rst_flags", {bus.first_o, bus.last_o}, 2'b00);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_ready", bus.ready_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;

    pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    model(pkt);
    send(pkt, 1'b1);
    drain("add");

    pkt = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h61, 8'h62, 8'h63};
    model(pkt);
    send(pkt, 1'b1);
    drain("echo3");

    pkt = '{8'hA1, 8'h00, 8'h02, 8'h00};
    model(pkt);
    send(pkt, 1'b0);
    pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    model(pkt);
    send(pkt, 1'b0);
    drain("short_then_add");

    pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB, 8'hEC, 8'h00, 8'h05, 8'h00, 8'h7A};
    model(pkt[0:5]);
    model(pkt[6:10]);
    send(pkt, 1'b0);
    drain("unknown_then_echo");

    pkt = '{8'hA2, 8'h00, 8'h04, 8'h00};
    model(pkt);
    send(pkt, 1'b1);
    drain("header_only");

    build(8'hA2, 16'h0404);
    model(pkt);
    send(pkt, 1'b0);
    drain("oversize");
    chk("oversize_idle", {bus.busy_o, bus.ready_o}, 2'b01);

    ready_force = 1'b0;
    pkt = '{8'hA1, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00};
    model(pkt);
    part = pkt[0:7];
    send(part, 1'b0);
    repeat (3) @(negedge clk);
    chk("bp_ready", bus.ready_o, 1'b0);
    chk("bp_valid", bus.valid_o, 1'b1);
    chk("bp_data", bus.data_o, 32'h00000001);
    ready_force = 1'b1;
    part = pkt[8:11];
    send(part, 1'b0);
    drain("backpressure");

    part = pkt[0:5];
    send(part, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_outputs", {bus.valid_o, bus.err_o, bus.data_o, bus.opcode_o, bus.len_o, bus.bytes_o},
        {1'b0, 1'b0, 32'd0, 8'd0, 16'd0, 3'd0});
    chk("mid_rst_busy", bus.busy_o, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    model(pkt);
    send(pkt, 1'b1);
    drain("after_reset");

    rand_ready = 1'b1;
    for (int p = 0; p < 25; p++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0)      len = $urandom_range(0, 3);
      else if (sel == 1) len = $urandom_range(1025, 1032);
      else               len = $urandom_range(4, 24);
      case ($urandom_range(0, 4))
        0:       build(8'hEC, len);
        1:       build(8'hA1, len);
        2:       build(8'hA2, len);
        3:       build(8'hA3, len);
        default: build(8'($urandom_range(0, 255)), len);
      endcase
      model(pkt);
      send(pkt, 1'b1);
    end
    drain("random");
    rand_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_alu_packet_parser.md
Name: uart_alu_packet_parser

Overview:
Byte-to-packet stage between the UART receiver and the ALU core inside uart_alu. Consumes received bytes over a valid/ready stream and decodes the 4-byte header (opcode, reserved, length LSB, length MSB). Assembles the payload into little-endian 32-bit words, each tagged with opcode, packet length, first/last flags and valid-byte count. Rejects malformed packets and discards their payload so the byte stream stays aligned.

Parameters:
MAX_LEN_P, 16'd1024, largest legal total packet length in bytes, header included.
OP_ECHO_P, 8'hEC, echo opcode.
OP_ADD_P, 8'hA1, 32-bit add opcode.
OP_MUL_P, 8'hA2, 32-bit multiply opcode.
OP_DIV_P, 8'hA3, 32-bit divide opcode.

Ports:
clk_i  in  1  system clock; the only clock.
rst_i  in  1  synchronous reset, active-low.
data_i  in  8  received byte.
valid_i  in  1  data_i is valid.
ready_o  out  1  byte accepted on a cycle where valid_i & ready_o.
opcode_o  out  8  opcode of the current packet.
len_o  out  16  total length of the current packet, in bytes.
data_o  out  32  payload word, little-endian, zero-padded.
bytes_o  out  3  valid bytes in data_o (0..4).
first_o  out  1  first word of the packet.
last_o  out  1  last word of the packet.
valid_o  out  1  output word valid.
ready_i  in  1  downstream accepts the word on valid_o & ready_i.
err_o  out  1  one-cycle pulse when a packet is rejected.
busy_o  out  1  high in any state other than OPCODE.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - State goes to OPCODE.
  - valid_o, err_o, first_o and last_o go to 0.
  - data_o, opcode_o, len_o and bytes_o go to 0.
  - The byte accumulator and counters are cleared.
  - Reset applied mid-packet drops the partial packet silently, with no err_o.
- Header states: OPCODE -> RSVD -> LEN_LO -> LEN_HI. One accepted byte per step; ready_o=1 in all four.
  - OPCODE latches opcode_o.
  - RSVD ignores its byte.
  - LEN_LO and LEN_HI latch len_o.
- On leaving LEN_HI, first match wins (L = the new len_o):
  - L<4: err_o pulses for 1 cycle; go to OPCODE.
  - Opcode is not one of the four, or L>MAX_LEN_P: err_o pulses; go to DISCARD with remaining = L-4. If remaining=0, go to OPCODE instead.
  - L==4: go to EMPTY.
  - Otherwise go to PAYLOAD with remaining = L-4.
- EMPTY:
  - Presents one marker word: data_o=0, bytes_o=0, first_o=last_o=1, valid_o=1.
  - ready_o=0 while in EMPTY.
  - Leaves for OPCODE on the output handshake.
- PAYLOAD:
  - Each accepted byte shifts into the accumulator at byte lane k = (bytes taken so far) mod 4, and decrements remaining.
  - A word is emitted when its 4th byte is accepted, or when remaining reaches 0.
  - On emission, data_o, bytes_o, first_o and last_o are registered and valid_o rises the next cycle (latency 1 cycle from the completing byte).
  - first_o=1 only on the packet's first word. last_o=1 only when remaining==0.
  - Unused upper bytes of a partial final word are zero.
- Output register:
  - valid_o holds, with all output fields stable, until valid_o & ready_i.
  - ready_o = 0 in PAYLOAD while valid_o & ~ready_i. This combinational path from ready_i is allowed.
  - A byte may be accepted in the same cycle the pending word is handed off, giving a sustained 1 byte/cycle.
- Packet end: after the last word's handshake, go to OPCODE.
  - The next header byte may be accepted in that same handshake cycle only if state is already OPCODE. Otherwise it is accepted from the following cycle.
- DISCARD: ready_o=1; accepted bytes decrement remaining; no output words; go to OPCODE when remaining hits 0.
- Counters and widths:
  - remaining is 16-bit and never wraps, because L>=4 is checked before subtraction.
  - The word byte index is 2-bit and wraps 3->0.
- Simultaneous events: err_o is asserted only in the LEN_HI exit cycle and never coincides with valid_o rising.

Test Plan:
- Add packet A1 00 0C 00 01 00 00 00 02 00 00 00, ready_i=1 -> two words: 0x00000001 (first=1, last=0, bytes=4), then 0x00000002 (first=0, last=1, bytes=4); opcode_o=A1, len_o=0x000C; no err_o.
- Echo EC 00 07 00 61 62 63 -> one word 0x00636261, bytes=3, first=last=1.
- Length 2 (A1 00 02 00), then a valid add packet -> err_o pulses once; the add packet decodes exactly as in the first scenario.
- Unknown opcode 55 00 06 00 AA BB, then echo EC 00 05 00 7A -> err_o pulse; AA and BB consumed with no output; then word 0x0000007A, bytes=1, first=last=1.
- Header-only A2 00 04 00 -> marker word, bytes=0, first=last=1. Length 0x0404 with MAX_LEN_P=1024 -> err_o; 1024 bytes discarded.
- Backpressure: hold ready_i=0 while streaming the add packet -> ready_o drops after byte 8; data_o stays 0x00000001 until ready_i=1; no byte lost.
- Reset mid-packet: rst_i=0 after byte 6 of the add packet -> all outputs 0, state OPCODE, no err_o; the next packet parses normally.
